// File: rtl/id_inst_queue_pkg.sv
// Shared decode constants for the IF/ID instruction queue.
// Opcode encodings match the codebase definitions used by fc and decode.
package id_inst_queue_pkg;

  localparam logic [6:0]  Jtype_J = 7'b1101111;  // JAL
  localparam logic [6:0]  Itype_J = 7'b1100111;  // JALR
  localparam logic [6:0]  Btype   = 7'b1100011;  // conditional branches
  localparam logic [31:0] IQ_NOP  = 32'h0000_0000;

  function automatic logic is_jump_op(input logic [6:0] op);
    return (op == Jtype_J) || (op == Itype_J) || (op == Btype);
  endfunction

endpackage

// File: rtl/iq_fifo_mem.sv
// Instruction queue storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the queue pointers.
module iq_fifo_mem #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/id_inst_queue.sv
// Instruction queue between Icache and decode: buffers {pc,inst} across fc stalls,
// drops in-flight Icache responses after a flush and pre-decodes a jump hint.
module id_inst_queue
  import id_inst_queue_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              DEPTH       = 4,
  parameter int              KILL_CYCLES = 1,
  parameter int              BYPASS      = 1,
  parameter logic [XLEN-1:0] NOP_INST    = XLEN'(IQ_NOP)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ic_valid_i,
  input  logic [XLEN-1:0]            ic_inst_i,
  input  logic [XLEN-1:0]            ic_pc_i,
  output logic                       iq_ready_o,
  input  logic                       fc_flush_i,
  input  logic                       fc_stall_i,
  output logic                       id_valid_o,
  output logic [XLEN-1:0]            id_inst_o,
  output logic [XLEN-1:0]            id_pc_o,
  output logic                       id_jump_hint_o,
  output logic [$clog2(DEPTH+1)-1:0] iq_count_o,
  output logic                       iq_empty_o,
  output logic                       iq_full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int KW = 2;

  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [KW-1:0]     kill_q, kill_d;
  logic              empty, full, push, bypass, wr_en, pop_mem;
  logic [2*XLEN-1:0] rdata;

  assign empty      = (cnt_q == '0);
  assign full       = (cnt_q == CW'(DEPTH));
  // Ready looks only at the registered count so stall never reaches the Icache combinationally.
  assign iq_ready_o = !full;
  assign push       = ic_valid_i & iq_ready_o & !fc_flush_i & (kill_q == '0);
  assign bypass     = (BYPASS != 0) & empty & push & !fc_stall_i;
  assign wr_en      = push & !bypass;
  assign id_valid_o = !fc_flush_i & (!empty | bypass);
  assign pop_mem    = id_valid_o & !fc_stall_i & !bypass;

  iq_fifo_mem #(
    .W     (2*XLEN),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_q),
    .wdata_i ({ic_pc_i, ic_inst_i}),
    .raddr_i (rd_q),
    .rdata_o (rdata)
  );

  always_comb begin
    id_inst_o = NOP_INST;
    id_pc_o   = '0;
    if (id_valid_o) begin
      if (bypass) begin
        id_inst_o = ic_inst_i;
        id_pc_o   = ic_pc_i;
      end else begin
        id_inst_o = rdata[XLEN-1:0];
        id_pc_o   = rdata[2*XLEN-1:XLEN];
      end
    end
  end

  assign id_jump_hint_o = id_valid_o & is_jump_op(id_inst_o[6:0]);

  always_comb begin
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    kill_d = (kill_q != '0) ? kill_q - KW'(1) : kill_q;
    if (fc_flush_i) begin
      rd_d   = '0;
      wr_d   = '0;
      cnt_d  = '0;
      kill_d = KW'(KILL_CYCLES);
    end else begin
      if (wr_en)   wr_d = wr_q + PW'(1);
      if (pop_mem) rd_d = rd_q + PW'(1);
      case ({wr_en, pop_mem})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      kill_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      kill_q <= kill_d;
    end
  end

  assign iq_count_o = cnt_q;
  assign iq_empty_o = empty;
  assign iq_full_o  = full;

endmodule

// File: tb/tb_id_inst_queue.sv
// Directed bench for id_inst_queue (DEPTH=4, KILL_CYCLES=1, BYPASS=1).
module tb_id_inst_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_valid_i, fc_flush_i, fc_stall_i;
  logic [31:0] ic_inst_i, ic_pc_i;
  logic        iq_ready_o, id_valid_o, id_jump_hint_o, iq_empty_o, iq_full_o;
  logic [31:0] id_inst_o, id_pc_o;
  logic [2:0]  iq_count_o;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  id_inst_queue #(
    .XLEN(32), .DEPTH(4), .KILL_CYCLES(1), .BYPASS(1), .NOP_INST(32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ic_valid_i     (ic_valid_i),
    .ic_inst_i      (ic_inst_i),
    .ic_pc_i        (ic_pc_i),
    .iq_ready_o     (iq_ready_o),
    .fc_flush_i     (fc_flush_i),
    .fc_stall_i     (fc_stall_i),
    .id_valid_o     (id_valid_o),
    .id_inst_o      (id_inst_o),
    .id_pc_o        (id_pc_o),
    .id_jump_hint_o (id_jump_hint_o),
    .iq_count_o     (iq_count_o),
    .iq_empty_o     (iq_empty_o),
    .iq_full_o      (iq_full_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic st, input logic fl);
    ic_valid_i = v;
    ic_pc_i    = pc;
    ic_inst_i  = inst;
    fc_stall_i = st;
    fc_flush_i = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] insts [3];
  logic [31:0] hint_inst [4];
  logic        hint_exp  [4];
  logic [31:0] push_pc, out_pc;
  int          mcnt, npush, cyc;
  logic        v, st, exp_vld, acc, pop;

  initial begin
    insts     = '{32'h00100093, 32'h00200113, 32'h00300193};
    hint_inst = '{32'h0000006F, 32'h00000063, 32'h00000013, 32'h00000067};
    hint_exp  = '{1'b1, 1'b1, 1'b0, 1'b1};

    // Reset values
    rst = 1'b1;
    ic_valid_i = 0; ic_pc_i = '0; ic_inst_i = '0; fc_stall_i = 0; fc_flush_i = 0;
    #1;
    chk("rst_ready", iq_ready_o, 1);
    chk("rst_valid", id_valid_o, 0);
    chk("rst_inst",  id_inst_o, 32'h0);
    chk("rst_pc",    id_pc_o, 32'h0);
    chk("rst_hint",  id_jump_hint_o, 0);
    chk("rst_empty", iq_empty_o, 1);
    chk("rst_full",  iq_full_o, 0);
    chk("rst_count", iq_count_o, 0);
    tick();
    rst = 1'b0;

    // 1: back-to-back pushes with no stall are bypassed straight to decode
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'(4*i), insts[i], 0, 0);
      chk("t1_valid", id_valid_o, 1);
      chk("t1_pc",    id_pc_o, 32'(4*i));
      chk("t1_inst",  id_inst_o, insts[i]);
      chk("t1_count", iq_count_o, 0);
      chk("t1_full",  iq_full_o, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    chk("t1_idle_valid", id_valid_o, 0);
    chk("t1_idle_empty", iq_empty_o, 1);

    // 2: stall fills the queue, Icache holds pc 0x10 while full, then drain
    for (int k = 0; k < 6; k++) begin
      drive(1, (k < 4) ? 32'(4*k) : 32'h10, 32'h00000013, 1, 0);
      chk("t2_count", iq_count_o, (k < 4) ? k : 4);
      chk("t2_full",  iq_full_o, (k >= 4) ? 1 : 0);
      chk("t2_ready", iq_ready_o, (k < 4) ? 1 : 0);
      chk("t2_valid", id_valid_o, (k > 0) ? 1 : 0);
      if (k > 0) chk("t2_head_pc", id_pc_o, 32'h0);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0);
      chk("t2_drain_valid", id_valid_o, 1);
      chk("t2_drain_pc",    id_pc_o, 32'(4*k));
      chk("t2_drain_count", iq_count_o, 32'(4-k));
      tick();
    end
    drive(0, 0, 0, 0, 0);
    chk("t2_empty", iq_empty_o, 1);

    // 3: flush with count=3 plus push and pop; next response killed, following one accepted
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h100 + 32'(4*k), 32'h00000013, 1, 0);
      tick();
    end
    drive(1, 32'h10C, 32'h00000013, 0, 1);
    chk("t3_pre_count", iq_count_o, 3);
    chk("t3_flush_valid", id_valid_o, 0);
    chk("t3_flush_inst",  id_inst_o, 32'h0);
    chk("t3_flush_pc",    id_pc_o, 32'h0);
    tick();
    drive(1, 32'h200, 32'h0000006F, 0, 0);
    chk("t3_post_count", iq_count_o, 0);
    chk("t3_kill_valid", id_valid_o, 0);
    chk("t3_kill_hint",  id_jump_hint_o, 0);
    tick();
    drive(1, 32'h204, 32'h00000013, 0, 0);
    chk("t3_accept_valid", id_valid_o, 1);
    chk("t3_accept_pc",    id_pc_o, 32'h204);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("t3_after_count", iq_count_o, 0);
    chk("t3_after_empty", iq_empty_o, 1);

    // 4: jump hint on bypass path, then on the stored path
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'h300 + 32'(4*k), hint_inst[k], 0, 0);
      chk("t4_hint", id_jump_hint_o, hint_exp[k]);
      tick();
    end
    drive(1, 32'h310, 32'hFE0008E3, 1, 0);
    chk("t4_stall_empty_hint", id_jump_hint_o, 0);
    tick();
    drive(0, 0, 0, 1, 0);
    chk("t4_mem_inst", id_inst_o, 32'hFE0008E3);
    chk("t4_mem_hint", id_jump_hint_o, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("t4_pop_hint", id_jump_hint_o, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("t4_empty_hint", id_jump_hint_o, 0);

    // 5: 10 pushes with stall toggling; pointers wrap, pc order strictly +4
    push_pc = 32'h400; out_pc = 32'h400; mcnt = 0; npush = 0; cyc = 0;
    while ((npush < 10 || mcnt > 0) && cyc < 60) begin
      v  = (npush < 10);
      st = (cyc % 3 != 2);
      drive(v, push_pc, 32'h00000013, st, 0);
      exp_vld = (mcnt > 0) || (v && !st);
      chk("t5_count", iq_count_o, 32'(mcnt));
      chk("t5_ready", iq_ready_o, (mcnt != 4) ? 1 : 0);
      chk("t5_valid", id_valid_o, exp_vld);
      if (exp_vld) chk("t5_pc", id_pc_o, out_pc);
      acc = v && (mcnt != 4);
      pop = exp_vld && !st;
      if (acc) begin push_pc += 4; npush++; end
      if (pop) out_pc += 4;
      mcnt = mcnt + (acc ? 1 : 0) - (pop ? 1 : 0);
      tick();
      cyc++;
    end
    chk("t5_done", (cyc < 60) ? 1 : 0, 1);
    chk("t5_last_pc", out_pc, 32'h428);
    drive(0, 0, 0, 0, 0);
    chk("t5_empty", iq_empty_o, 1);

    // 6: asynchronous reset with two entries queued
    drive(1, 32'h500, 32'h00000013, 1, 0);
    tick();
    drive(1, 32'h504, 32'h00000013, 1, 0);
    tick();
    drive(0, 0, 0, 1, 0);
    chk("t6_pre_count", iq_count_o, 2);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", id_valid_o, 0);
    chk("t6_rst_empty", iq_empty_o, 1);
    chk("t6_rst_ready", iq_ready_o, 1);
    chk("t6_rst_count", iq_count_o, 0);
    tick();
    rst = 1'b0;
    drive(1, 32'h600, 32'h0000006F, 0, 0);
    chk("t6_after_valid", id_valid_o, 1);
    chk("t6_after_pc",    id_pc_o, 32'h600);
    chk("t6_after_hint",  id_jump_hint_o, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("t6_final_empty", iq_empty_o, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
